// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the magnitude helper can handle.
    localparam int MAX_W = 256;

    function automatic int calc_steps(input int dw, input int bpc);
        return dw / bpc;
    endfunction

    function automatic int calc_cnt_w(input int dw, input int bpc);
        return $clog2(dw / bpc + 1);
    endfunction

    // Magnitude of the low w bits of v; raw value when sgn is 0.
    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v,
                                                   input int w,
                                                   input logic sgn);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        if (sgn && v[w-1])
            return (~v + MAX_W'(1)) & mask;
        return v & mask;
    endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One BUSY-cycle slice: adds mcand times a BPC-bit multiplier digit into the accumulator.
module seq_mul_step
    import seq_mul_pkg::*;
#(
    parameter int PW  = 128,
    parameter int BPC = 1
) (
    input  logic [PW-1:0]  acc_in,
    input  logic [PW-1:0]  mcand,
    input  logic [BPC-1:0] bits,
    output logic [PW-1:0]  acc_out
);

    always_comb begin
        acc_out = acc_in;
        for (int i = 0; i < BPC; i++) begin
            if (bits[i])
                acc_out = acc_out + (mcand << i);
        end
    end

endmodule

// File: rtl/seq_mul.sv
// Multi-cycle signed/unsigned multiplier, BITS_PER_CYCLE multiplier bits per clock.
// Optional overflow flag output enabled by defining SEQ_MUL_OVF_EN.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int DATAWIDTH      = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] prod
`ifdef SEQ_MUL_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int N     = calc_steps(DATAWIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = calc_cnt_w(DATAWIDTH, BITS_PER_CYCLE);
    localparam int PW    = 2 * DATAWIDTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);

    if (DATAWIDTH < 2) begin : g_chk_width
        $error("seq_mul: DATAWIDTH must be at least 2");
    end
    if (DATAWIDTH > MAX_W) begin : g_chk_max
        $error("seq_mul: DATAWIDTH exceeds magnitude helper width");
    end
    if ((DATAWIDTH % BITS_PER_CYCLE) != 0) begin : g_chk_bpc
        $error("seq_mul: BITS_PER_CYCLE must divide DATAWIDTH");
    end

    state_t               state, state_nxt;
    logic [PW-1:0]        mcand_sh;
    logic [PW-1:0]        acc;
    logic [PW-1:0]        acc_step;
    logic [DATAWIDTH-1:0] mplier;
    logic [DATAWIDTH-1:0] a_mag, b_mag;
    logic [DATAWIDTH-1:0] prod_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 res_neg;
    logic                 last_step;

    assign a_mag     = DATAWIDTH'(magnitude(MAX_W'(a), DATAWIDTH, sgn));
    assign b_mag     = DATAWIDTH'(magnitude(MAX_W'(b), DATAWIDTH, sgn));
    assign last_step = (cnt == CNT_W'(1));

    seq_mul_step #(
        .PW  (PW),
        .BPC (BITS_PER_CYCLE)
    ) u_step (
        .acc_in  (acc),
        .mcand   (mcand_sh),
        .bits    (mplier[BITS_PER_CYCLE-1:0]),
        .acc_out (acc_step)
    );

`ifdef SEQ_MUL_OVF_EN
    logic          res_sgn;
    logic          ovf_nxt;
    logic [PW-1:0] full_prod;

    assign full_prod = res_neg ? (~acc_step + PW'(1)) : acc_step;
    assign prod_nxt  = full_prod[DATAWIDTH-1:0];

    // Signed overflow: the top DATAWIDTH+1 bits must all be copies of the sign.
    always_comb begin
        ovf_nxt = |full_prod[PW-1:DATAWIDTH];
        if (res_sgn)
            ovf_nxt = !((&full_prod[PW-1:DATAWIDTH-1]) || !(|full_prod[PW-1:DATAWIDTH-1]));
    end
`else
    // Low bits of a two's-complement negation depend only on the low bits.
    assign prod_nxt = res_neg ? (~acc_step[DATAWIDTH-1:0] + DATAWIDTH'(1))
                              : acc_step[DATAWIDTH-1:0];
`endif

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mcand_sh <= '0;
            acc      <= '0;
            mplier   <= '0;
            cnt      <= '0;
            res_neg  <= 1'b0;
            prod     <= '0;
`ifdef SEQ_MUL_OVF_EN
            res_sgn  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_sh <= PW'(a_mag);
                        mplier   <= b_mag;
                        res_neg  <= sgn & (a[DATAWIDTH-1] ^ b[DATAWIDTH-1]);
                        acc      <= '0;
                        cnt      <= CNT_LOAD;
`ifdef SEQ_MUL_OVF_EN
                        res_sgn  <= sgn;
`endif
                    end
                end
                BUSY: begin
                    acc      <= acc_step;
                    mcand_sh <= mcand_sh << BITS_PER_CYCLE;
                    mplier   <= mplier >> BITS_PER_CYCLE;
                    cnt      <= cnt - CNT_W'(1);
                    if (last_step) begin
                        prod <= prod_nxt;
`ifdef SEQ_MUL_OVF_EN
                        ovf  <= ovf_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: DATAWIDTH=8 with BITS_PER_CYCLE=1 and 2.
// Overflow checks are compiled in when SEQ_MUL_OVF_EN is defined.
module tb_seq_mul;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          sgn = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_valid1 = 1'b0;
    logic          in_valid2 = 1'b0;
    logic          in_ready1, in_ready2;
    logic          out_valid1, out_valid2;
    logic [DW-1:0] prod1, prod2;
`ifdef SEQ_MUL_OVF_EN
    logic          ovf1, ovf2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] pa [3] = '{8'h03, 8'h10, 8'hF0};
    logic [DW-1:0] pb [3] = '{8'h04, 8'h10, 8'h02};
    logic [DW-1:0] pe [3] = '{8'h0C, 8'h00, 8'hE0};

    always #5 Clk = ~Clk;

    seq_mul #(.DATAWIDTH(DW), .BITS_PER_CYCLE(1)) dut1 (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .prod      (prod1)
`ifdef SEQ_MUL_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    seq_mul #(.DATAWIDTH(DW), .BITS_PER_CYCLE(2)) dut2 (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .prod      (prod2)
`ifdef SEQ_MUL_OVF_EN
        ,
        .ovf       (ovf2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction with out_ready held high; called at #1 after an edge.
    task automatic run(input int which, input logic [DW-1:0] oa, input logic [DW-1:0] ob,
                       input logic os, input logic [DW-1:0] ep, input logic eo,
                       input int n, input string tag);
        int k;
        a = oa; b = ob; sgn = os; out_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(which == 1 ? in_ready1 : in_ready2), 32'd1);
        if (which == 1) in_valid1 = 1'b1;
        else            in_valid2 = 1'b1;
        @(posedge Clk); #1;
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        a = 8'hA5; b = 8'h5A; sgn = ~os;
        k = 0;
        while (k < 40) begin
            @(posedge Clk); #1;
            k++;
            if (which == 1 ? out_valid1 : out_valid2) break;
        end
        chk({tag, "_lat"}, 32'(k), 32'(n));
        chk({tag, "_prod"}, 32'(which == 1 ? prod1 : prod2), 32'(ep));
`ifdef SEQ_MUL_OVF_EN
        chk({tag, "_ovf"}, 32'(which == 1 ? ovf1 : ovf2), 32'(eo));
`else
        if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
        @(posedge Clk); #1;
        chk({tag, "_idle"}, 32'(which == 1 ? in_ready1 : in_ready2), 32'd1);
    endtask

    initial begin
        int k;
        int idx, ridx, cyc;
        int acc_cyc [3];
        logic fire, stale;

        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_valid", 32'(out_valid1), 32'd0);
        chk("rst_prod",  32'(prod1), 32'd0);
        chk("rst_rdy",   32'(in_ready1), 32'd1);
        chk("rst_prod2", 32'(prod2), 32'd0);
`ifdef SEQ_MUL_OVF_EN
        chk("rst_ovf", 32'(ovf1), 32'd0);
`endif
        Rst = 1'b0;

        run(1, 8'd200, 8'd3,  1'b0, 8'h58, 1'b1, 8, "u200x3");
        run(1, 8'hF9,  8'h06, 1'b1, 8'hD6, 1'b0, 8, "s_m7x6");
        run(1, 8'h80,  8'hFF, 1'b1, 8'h80, 1'b1, 8, "s_min_m1");
        run(1, 8'h00,  8'h55, 1'b0, 8'h00, 1'b0, 8, "u_zero");
        run(1, 8'hFF,  8'hFF, 1'b0, 8'h01, 1'b1, 8, "u_ffxff");
        run(1, 8'h7F,  8'h7F, 1'b1, 8'h01, 1'b1, 8, "s_7fx7f");

        // Backpressure: result must hold and new requests must be ignored.
        out_ready = 1'b0;
        a = 8'd5; b = 8'd7; sgn = 1'b0; in_valid1 = 1'b1;
        @(posedge Clk); #1;
        in_valid1 = 1'b0;
        k = 0;
        while (k < 40 && !out_valid1) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("bp_lat", 32'(k), 32'd8);
        chk("bp_rdy0", 32'(in_ready1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid1 = 1'b1; a = 8'h11; b = 8'h22;
            @(posedge Clk); #1;
            chk("bp_valid", 32'(out_valid1), 32'd1);
            chk("bp_prod",  32'(prod1), 32'h23);
            chk("bp_rdy",   32'(in_ready1), 32'd0);
        end
        in_valid1 = 1'b0; out_ready = 1'b1;
        @(posedge Clk); #1;
        chk("bp_release", 32'(in_ready1), 32'd1);
        chk("bp_outv",    32'(out_valid1), 32'd0);

        // Reset in the middle of BUSY discards the transaction.
        a = 8'd15; b = 8'd15; sgn = 1'b0; in_valid1 = 1'b1;
        @(posedge Clk); #1;
        in_valid1 = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk("rb_valid", 32'(out_valid1), 32'd0);
        chk("rb_prod",  32'(prod1), 32'd0);
        chk("rb_rdy",   32'(in_ready1), 32'd1);
        Rst = 1'b0;
        stale = 1'b0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (out_valid1) stale = 1'b1;
        end
        chk("rb_stale", 32'(stale), 32'd0);
        run(1, 8'd2, 8'd3, 1'b0, 8'h06, 1'b0, 8, "after_rst");

        // Back-to-back with in_valid held high.
        idx = 0; ridx = 0; cyc = 0;
        sgn = 1'b0; out_ready = 1'b1;
        a = pa[0]; b = pb[0]; in_valid1 = 1'b1;
        while (ridx < 3 && cyc < 200) begin
            fire = in_valid1 && in_ready1;
            @(posedge Clk); #1;
            cyc++;
            if (fire) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    a = pa[idx]; b = pb[idx];
                end else begin
                    in_valid1 = 1'b0;
                end
            end
            if (out_valid1) begin
                chk("b2b_prod", 32'(prod1), 32'(pe[ridx]));
                ridx++;
            end
        end
        in_valid1 = 1'b0;
        chk("b2b_accepts", 32'(idx), 32'd3);
        chk("b2b_results", 32'(ridx), 32'd3);
        chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
        chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
        @(posedge Clk); #1;

        run(2, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b1, 4, "bpc2_ff");
        run(2, 8'hF9, 8'h06, 1'b1, 8'hD6, 1'b0, 4, "bpc2_s");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
